// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register: captures execute-stage results and control for the memory stage,
// with stall (hold), flush (bubble insert) and a saturating count of inserted bubbles.
module ex_mem_register #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             ValidIn,
  input  logic             BranchIn,
  input  logic             NotZeroIn,
  input  logic             MemReadIn,
  input  logic             MemWriteIn,
  input  logic             RegWriteIn,
  input  logic             MemToRegIn,
  input  logic             LoadStoreByteIn,
  input  logic             LoadStoreHalfIn,
  input  logic [1:0]       JumpIn,
  input  logic             ZeroIn,
  input  logic [31:0]      ALUIn,
  input  logic [31:0]      BranchTargetAddressIn,
  input  logic [31:0]      PCValueForJALIn,
  input  logic [31:0]      MemoryWriteDataIn,
  input  logic [31:0]      InstructionIn,
  input  logic [4:0]       DestinationRegIn,
  output logic             ValidOut,
  output logic             BranchOut,
  output logic             NotZeroOut,
  output logic             MemReadOut,
  output logic             MemWriteOut,
  output logic             RegWriteOut,
  output logic             MemToRegOut,
  output logic             LoadStoreByteOut,
  output logic             LoadStoreHalfOut,
  output logic [1:0]       JumpOut,
  output logic             ZeroOut,
  output logic [31:0]      ALUOut,
  output logic [31:0]      BranchTargetAddressOut,
  output logic [31:0]      PCValueForJALOut,
  output logic [31:0]      MemoryWriteDataOut,
  output logic [31:0]      InstructionOut,
  output logic [4:0]       DestinationRegOut,
  output logic [CNT_W-1:0] BubbleCountOut
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic             r_valid, r_branch, r_not_zero, r_mem_read, r_mem_write;
  logic             r_reg_write, r_mem_to_reg, r_ls_byte, r_ls_half, r_zero;
  logic [1:0]       r_jump;
  logic [DW-1:0]    r_alu, r_bta, r_pc_jal, r_mem_wdata, r_instr;
  logic [RW-1:0]    r_dest;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic             w_valid, w_branch, w_not_zero, w_mem_read, w_mem_write;
  logic             w_reg_write, w_mem_to_reg, w_ls_byte, w_ls_half, w_zero;
  logic [1:0]       w_jump;
  logic [DW-1:0]    w_alu, w_bta, w_pc_jal, w_mem_wdata, w_instr;
  logic [RW-1:0]    w_dest;
  logic [CNT_W-1:0] w_bubble_cnt;
  logic             w_cnt_sat;

  assign w_cnt_sat = (r_bubble_cnt == {CNT_W{1'b1}});

  // Next-entry selection: flush beats stall; control bits of an invalid entry are forced to 0.
  always_comb begin
    w_valid      = r_valid;
    w_branch     = r_branch;
    w_not_zero   = r_not_zero;
    w_mem_read   = r_mem_read;
    w_mem_write  = r_mem_write;
    w_reg_write  = r_reg_write;
    w_mem_to_reg = r_mem_to_reg;
    w_ls_byte    = r_ls_byte;
    w_ls_half    = r_ls_half;
    w_jump       = r_jump;
    w_zero       = r_zero;
    w_alu        = r_alu;
    w_bta        = r_bta;
    w_pc_jal     = r_pc_jal;
    w_mem_wdata  = r_mem_wdata;
    w_instr      = r_instr;
    w_dest       = r_dest;
    w_bubble_cnt = r_bubble_cnt;

    if (Flush) begin
      w_valid      = 1'b0;
      w_branch     = 1'b0;
      w_not_zero   = NotZeroIn & ValidIn;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_to_reg = 1'b0;
      w_ls_byte    = 1'b0;
      w_ls_half    = 1'b0;
      w_jump       = 2'b00;
      w_zero       = ZeroIn;
      w_alu        = ALUIn;
      w_bta        = BranchTargetAddressIn;
      w_pc_jal     = PCValueForJALIn;
      w_mem_wdata  = MemoryWriteDataIn;
      w_instr      = '0;
      w_dest       = DestinationRegIn;
      if (r_valid && !w_cnt_sat) begin
        w_bubble_cnt = r_bubble_cnt + CNT_W'(1);
      end
    end else if (!Stall) begin
      w_valid      = ValidIn;
      w_branch     = BranchIn & ValidIn;
      w_not_zero   = NotZeroIn & ValidIn;
      w_mem_read   = MemReadIn & ValidIn;
      w_mem_write  = MemWriteIn & ValidIn;
      w_reg_write  = RegWriteIn & ValidIn;
      w_mem_to_reg = MemToRegIn & ValidIn;
      w_ls_byte    = LoadStoreByteIn & ValidIn;
      w_ls_half    = LoadStoreHalfIn & ValidIn;
      w_jump       = JumpIn & {2{ValidIn}};
      w_zero       = ZeroIn;
      w_alu        = ALUIn;
      w_bta        = BranchTargetAddressIn;
      w_pc_jal     = PCValueForJALIn;
      w_mem_wdata  = MemoryWriteDataIn;
      w_instr      = InstructionIn;
      w_dest       = DestinationRegIn;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_valid      <= 1'b0;
      r_branch     <= 1'b0;
      r_not_zero   <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_ls_byte    <= 1'b0;
      r_ls_half    <= 1'b0;
      r_jump       <= 2'b00;
      r_zero       <= 1'b0;
      r_alu        <= '0;
      r_bta        <= '0;
      r_pc_jal     <= '0;
      r_mem_wdata  <= '0;
      r_instr      <= '0;
      r_dest       <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_valid      <= w_valid;
      r_branch     <= w_branch;
      r_not_zero   <= w_not_zero;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_reg_write  <= w_reg_write;
      r_mem_to_reg <= w_mem_to_reg;
      r_ls_byte    <= w_ls_byte;
      r_ls_half    <= w_ls_half;
      r_jump       <= w_jump;
      r_zero       <= w_zero;
      r_alu        <= w_alu;
      r_bta        <= w_bta;
      r_pc_jal     <= w_pc_jal;
      r_mem_wdata  <= w_mem_wdata;
      r_instr      <= w_instr;
      r_dest       <= w_dest;
      r_bubble_cnt <= w_bubble_cnt;
    end
  end

  assign ValidOut               = r_valid;
  assign BranchOut              = r_branch;
  assign NotZeroOut             = r_not_zero;
  assign MemReadOut             = r_mem_read;
  assign MemWriteOut            = r_mem_write;
  assign RegWriteOut            = r_reg_write;
  assign MemToRegOut            = r_mem_to_reg;
  assign LoadStoreByteOut       = r_ls_byte;
  assign LoadStoreHalfOut       = r_ls_half;
  assign JumpOut                = r_jump;
  assign ZeroOut                = r_zero;
  assign ALUOut                 = r_alu;
  assign BranchTargetAddressOut = r_bta;
  assign PCValueForJALOut       = r_pc_jal;
  assign MemoryWriteDataOut     = r_mem_wdata;
  assign InstructionOut         = r_instr;
  assign DestinationRegOut      = r_dest;
  assign BubbleCountOut         = r_bubble_cnt;

endmodule

// File: tb/tb_ex_mem_register.sv
// Directed bench for ex_mem_register: a default-width instance plus a CNT_W=2 instance
// sharing the same stimulus, used for counter saturation.
module tb_ex_mem_register;

  logic        Clk = 1'b0;
  logic        Rst, Stall, Flush, ValidIn, BranchIn, NotZeroIn, MemReadIn, MemWriteIn;
  logic        RegWriteIn, MemToRegIn, LoadStoreByteIn, LoadStoreHalfIn, ZeroIn;
  logic [1:0]  JumpIn;
  logic [31:0] ALUIn, BranchTargetAddressIn, PCValueForJALIn, MemoryWriteDataIn, InstructionIn;
  logic [4:0]  DestinationRegIn;

  logic        ValidOut, BranchOut, NotZeroOut, MemReadOut, MemWriteOut, RegWriteOut;
  logic        MemToRegOut, LoadStoreByteOut, LoadStoreHalfOut, ZeroOut;
  logic [1:0]  JumpOut;
  logic [31:0] ALUOut, BranchTargetAddressOut, PCValueForJALOut, MemoryWriteDataOut, InstructionOut;
  logic [4:0]  DestinationRegOut;
  logic [15:0] BubbleCountOut;

  logic        s_valid, s_branch, s_not_zero, s_mem_read, s_mem_write, s_reg_write;
  logic        s_mem_to_reg, s_ls_byte, s_ls_half, s_zero;
  logic [1:0]  s_jump;
  logic [31:0] s_alu, s_bta, s_pc_jal, s_mem_wdata, s_instr;
  logic [4:0]  s_dest;
  logic [1:0]  s_bubble_cnt;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  ex_mem_register u_dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
    .ValidIn(ValidIn), .BranchIn(BranchIn), .NotZeroIn(NotZeroIn), .MemReadIn(MemReadIn),
    .MemWriteIn(MemWriteIn), .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn),
    .LoadStoreByteIn(LoadStoreByteIn), .LoadStoreHalfIn(LoadStoreHalfIn), .JumpIn(JumpIn),
    .ZeroIn(ZeroIn), .ALUIn(ALUIn), .BranchTargetAddressIn(BranchTargetAddressIn),
    .PCValueForJALIn(PCValueForJALIn), .MemoryWriteDataIn(MemoryWriteDataIn),
    .InstructionIn(InstructionIn), .DestinationRegIn(DestinationRegIn),
    .ValidOut(ValidOut), .BranchOut(BranchOut), .NotZeroOut(NotZeroOut), .MemReadOut(MemReadOut),
    .MemWriteOut(MemWriteOut), .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut),
    .LoadStoreByteOut(LoadStoreByteOut), .LoadStoreHalfOut(LoadStoreHalfOut), .JumpOut(JumpOut),
    .ZeroOut(ZeroOut), .ALUOut(ALUOut), .BranchTargetAddressOut(BranchTargetAddressOut),
    .PCValueForJALOut(PCValueForJALOut), .MemoryWriteDataOut(MemoryWriteDataOut),
    .InstructionOut(InstructionOut), .DestinationRegOut(DestinationRegOut),
    .BubbleCountOut(BubbleCountOut)
  );

  ex_mem_register #(.CNT_W(2)) u_dut_sat (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
    .ValidIn(ValidIn), .BranchIn(BranchIn), .NotZeroIn(NotZeroIn), .MemReadIn(MemReadIn),
    .MemWriteIn(MemWriteIn), .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn),
    .LoadStoreByteIn(LoadStoreByteIn), .LoadStoreHalfIn(LoadStoreHalfIn), .JumpIn(JumpIn),
    .ZeroIn(ZeroIn), .ALUIn(ALUIn), .BranchTargetAddressIn(BranchTargetAddressIn),
    .PCValueForJALIn(PCValueForJALIn), .MemoryWriteDataIn(MemoryWriteDataIn),
    .InstructionIn(InstructionIn), .DestinationRegIn(DestinationRegIn),
    .ValidOut(s_valid), .BranchOut(s_branch), .NotZeroOut(s_not_zero), .MemReadOut(s_mem_read),
    .MemWriteOut(s_mem_write), .RegWriteOut(s_reg_write), .MemToRegOut(s_mem_to_reg),
    .LoadStoreByteOut(s_ls_byte), .LoadStoreHalfOut(s_ls_half), .JumpOut(s_jump),
    .ZeroOut(s_zero), .ALUOut(s_alu), .BranchTargetAddressOut(s_bta),
    .PCValueForJALOut(s_pc_jal), .MemoryWriteDataOut(s_mem_wdata),
    .InstructionOut(s_instr), .DestinationRegOut(s_dest),
    .BubbleCountOut(s_bubble_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    Stall = 0; Flush = 0; ValidIn = 0; BranchIn = 0; NotZeroIn = 0; MemReadIn = 0;
    MemWriteIn = 0; RegWriteIn = 0; MemToRegIn = 0; LoadStoreByteIn = 0; LoadStoreHalfIn = 0;
    JumpIn = 2'b00; ZeroIn = 0; ALUIn = '0; BranchTargetAddressIn = '0; PCValueForJALIn = '0;
    MemoryWriteDataIn = '0; InstructionIn = '0; DestinationRegIn = '0;
  endtask

  task automatic check_all_zero(input string tag);
    logic [15:0] ctl;
    logic [31:0] dor;
    ctl = {ValidOut, BranchOut, NotZeroOut, MemReadOut, MemWriteOut, RegWriteOut, MemToRegOut,
           LoadStoreByteOut, LoadStoreHalfOut, JumpOut, ZeroOut, DestinationRegOut};
    dor = ALUOut | BranchTargetAddressOut | PCValueForJALOut | MemoryWriteDataOut;
    check({tag, "_ctl"}, 64'(ctl), 64'h0);
    check({tag, "_data"}, 64'(dor), 64'h0);
    check({tag, "_instr"}, 64'(InstructionOut), 64'h0);
    check({tag, "_bcnt"}, 64'(BubbleCountOut), 64'h0);
    check({tag, "_bcnt_sat"}, 64'(s_bubble_cnt), 64'h0);
  endtask

  initial begin
    Rst = 1;
    clear_inputs();
    ValidIn = 1; RegWriteIn = 1; ALUIn = 32'hDEAD_BEEF; Flush = 1;
    step();
    check_all_zero("reset");
    clear_inputs();
    Rst = 0;

    // Normal capture
    ValidIn = 1; RegWriteIn = 1; ALUIn = 32'h0000_0010; DestinationRegIn = 5'd8;
    InstructionIn = 32'h0123_4567; JumpIn = 2'b01;
    step();
    check("cap_regwrite", 64'(RegWriteOut), 64'h1);
    check("cap_alu", 64'(ALUOut), 64'h10);
    check("cap_dest", 64'(DestinationRegOut), 64'd8);
    check("cap_valid", 64'(ValidOut), 64'h1);
    check("cap_jump", 64'(JumpOut), 64'h1);
    check("cap_instr", 64'(InstructionOut), 64'h0123_4567);

    // Stall holds for 3 cycles, then captures
    JumpIn = 2'b00;
    ALUIn = 32'hA5A5_A5A5;
    step();
    check("stall_load", 64'(ALUOut), 64'hA5A5_A5A5);
    Stall = 1; ALUIn = 32'h1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", 64'(ALUOut), 64'hA5A5_A5A5);
    end
    Stall = 0;
    step();
    check("stall_release", 64'(ALUOut), 64'h1);

    // Flush with stall on a valid store
    RegWriteIn = 0; MemWriteIn = 1; InstructionIn = 32'hAC22_0004;
    step();
    check("sw_memwrite", 64'(MemWriteOut), 64'h1);
    check("sw_bcnt0", 64'(BubbleCountOut), 64'h0);
    Stall = 1; Flush = 1;
    step();
    check("flush_memwrite", 64'(MemWriteOut), 64'h0);
    check("flush_valid", 64'(ValidOut), 64'h0);
    check("flush_instr", 64'(InstructionOut), 64'h0);
    check("flush_bcnt", 64'(BubbleCountOut), 64'h1);
    step();
    check("flush_held_bcnt", 64'(BubbleCountOut), 64'h1);
    Stall = 0; Flush = 0;

    // Invalid entry: controls captured as 0
    ValidIn = 0; MemWriteIn = 1; RegWriteIn = 1; JumpIn = 2'b10; MemReadIn = 1;
    ALUIn = 32'h55;
    step();
    check("inv_memwrite", 64'(MemWriteOut), 64'h0);
    check("inv_regwrite", 64'(RegWriteOut), 64'h0);
    check("inv_jump", 64'(JumpOut), 64'h0);
    check("inv_memread", 64'(MemReadOut), 64'h0);
    check("inv_valid", 64'(ValidOut), 64'h0);
    check("inv_alu", 64'(ALUOut), 64'h55);

    // Saturation of the 2-bit counter
    clear_inputs();
    Rst = 1;
    #1;
    check("sat_reset", 64'(s_bubble_cnt), 64'h0);
    step();
    Rst = 0;
    for (int i = 0; i < 5; i++) begin
      ValidIn = 1; MemWriteIn = 1; Flush = 0;
      step();
      Flush = 1;
      step();
      check("sat_bcnt", 64'(s_bubble_cnt), 64'((i < 3) ? i + 1 : 3));
      check("wide_bcnt", 64'(BubbleCountOut), 64'(i + 1));
    end
    Flush = 0;

    // Asynchronous reset mid-cycle, during stall+flush
    clear_inputs();
    ValidIn = 1; ALUIn = 32'hFFFF_FFFF;
    step();
    check("arst_pre_valid", 64'(ValidOut), 64'h1);
    check("arst_pre_alu", 64'(ALUOut), 64'hFFFF_FFFF);
    Stall = 1; Flush = 1;
    #3;
    Rst = 1;
    #1;
    check_all_zero("arst");
    step();
    check_all_zero("arst_hold");
    Rst = 0; Stall = 0; Flush = 0;
    ValidIn = 1; ALUIn = 32'h1234; RegWriteIn = 1;
    step();
    check("arst_resume_alu", 64'(ALUOut), 64'h1234);
    check("arst_resume_valid", 64'(ValidOut), 64'h1);
    check("arst_resume_regwrite", 64'(RegWriteOut), 64'h1);
    check("arst_resume_bcnt", 64'(BubbleCountOut), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_register.md
EX_MEM_REGISTER -- requirements
Module: ex_mem_register

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-002 SHALL have port Clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port Rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port Stall, input, 1, hold all registered state this cycle.
REQ-005 SHALL have port Flush, input, 1, replace the captured entry with a bubble.
REQ-006 SHALL have ports ValidIn and ValidOut, in and out, 1, entry-holds-a-real-instruction flag.
REQ-007 SHALL have ports BranchIn and BranchOut, in and out, 1, conditional-branch control.
REQ-008 SHALL have ports NotZeroIn and NotZeroOut, in and out, 1, selects branch-on-not-zero.
REQ-009 SHALL have ports MemReadIn and MemReadOut, in and out, 1, data memory read enable.
REQ-010 SHALL have ports MemWriteIn and MemWriteOut, in and out, 1, data memory write enable.
REQ-011 SHALL have ports RegWriteIn and RegWriteOut, in and out, 1, register file write enable.
REQ-012 SHALL have ports MemToRegIn and MemToRegOut, in and out, 1, write-back source select.
REQ-013 SHALL have ports LoadStoreByteIn/Out and LoadStoreHalfIn/Out, in and out, 1 each, access size.
REQ-014 SHALL have ports JumpIn and JumpOut, in and out, 2, jump type; 0 means none.
REQ-015 SHALL have ports ZeroIn and ZeroOut, in and out, 1, ALU zero flag.
REQ-016 SHALL have ports ALUIn and ALUOut, in and out, 32, ALU result and memory address.
REQ-017 SHALL have ports BranchTargetAddressIn/Out, PCValueForJALIn/Out, MemoryWriteDataIn/Out and InstructionIn/Out, in and out, 32 each, datapath payload.
REQ-018 SHALL have ports DestinationRegIn and DestinationRegOut, in and out, 5, write-back register index.
REQ-019 SHALL have port BubbleCountOut, output, CNT_W, count of bubbles inserted by Flush.

Function
REQ-020 All ...Out ports SHALL be driven directly from flops, with no combinational path from any input.
REQ-021 If Stall=0 and Flush=0, every field SHALL capture its ...In value at the edge, giving a latency of 1 cycle.
REQ-022 If Stall=1 and Flush=0, every field SHALL hold its current value.
REQ-023 Flush=1 SHALL win over Stall at the edge.
REQ-024 On Flush=1, ValidOut, BranchOut, MemReadOut, MemWriteOut, RegWriteOut, MemToRegOut, LoadStoreByteOut and LoadStoreHalfOut SHALL be cleared to 0.
REQ-025 On Flush=1, JumpOut SHALL be cleared to 2'b00 and InstructionOut to 32'h0 (nop).
REQ-026 On Flush=1, the other payload fields SHALL capture their inputs as don't-care data.
REQ-027 On Flush=1 and Stall=0 with ValidIn=0, ValidOut SHALL be 0 and all control outputs cleared, the same as a normal bubble.
REQ-028 Any control In asserted while ValidIn=0 SHALL be captured as 0, so an invalid entry never writes memory or registers.
REQ-029 BubbleCountOut SHALL increment by 1 on each edge where Flush=1 and the pre-edge ValidOut=1.
REQ-030 BubbleCountOut SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031 BubbleCountOut SHALL be unaffected by Stall.
REQ-032 A Flush held for N cycles SHALL count at most once, because ValidOut is 0 after the first flushed edge.

Reset
REQ-033 Rst=1 SHALL clear every output to 0 immediately, without waiting for a clock edge, including BubbleCountOut and InstructionOut=32'h0.
REQ-034 While Rst=1, Stall, Flush and all In ports SHALL be ignored.
REQ-035 The first capture after Rst deasserts SHALL occur on the first rising Clk edge with Rst=0.
REQ-036 Rst asserted mid-stall or mid-flush SHALL leave no residue of that operation after deassertion.

Verification
REQ-037 SHALL test normal capture: ValidIn=1, RegWriteIn=1, ALUIn=32'h0000_0010, DestinationRegIn=5'd8 -> one edge later RegWriteOut=1, ALUOut=32'h10, DestinationRegOut=8, ValidOut=1.
REQ-038 SHALL test stall: load ALUIn=32'hA5A5_A5A5, then hold Stall=1 for 3 cycles while ALUIn=32'h1 -> ALUOut stays 32'hA5A5_A5A5 for 3 cycles, then becomes 32'h1 one edge after Stall falls.
REQ-039 SHALL test Flush with Stall on a valid sw entry (MemWriteIn=1): Stall=1 and Flush=1 together -> MemWriteOut=0, ValidOut=0, InstructionOut=0, BubbleCountOut increments from 0 to 1.
REQ-040 SHALL test invalid capture: ValidIn=0 with MemWriteIn=1, RegWriteIn=1, JumpIn=2'b10 -> MemWriteOut=0, RegWriteOut=0, JumpOut=0.
REQ-041 SHALL test counter saturation with CNT_W=2: 5 flushes, each on a valid entry -> BubbleCountOut reads 1, 2, 3, 3, 3.
REQ-042 SHALL test asynchronous reset: raise Rst between clock edges while ValidOut=1 and ALUOut=32'hFFFF_FFFF -> all outputs are 0 before the next edge, and capture resumes on the first edge after Rst falls.
